// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and slot-width helper for the TDM demux
package tdm_pkg;
  typedef enum logic {HUNT, LOCK} state_t;
  localparam int N_CH_DEF = 4;
  localparam int SEL_W_DEF = $clog2(N_CH_DEF);
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-N_CH slot index with clear, load-to-1 and increment
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [SEL_W-1:0] slot,
  output logic             last
);
  assign last = (slot == SEL_W'(N_CH - 1));
  // clear wins over load, load over increment; wrap is explicit so non-power-of-2 N_CH works
  always_ff @(posedge clk or posedge rst)
    if (rst) slot <= '0;
    else if (clr) slot <= '0;
    else if (load1) slot <= SEL_W'(1);
    else if (inc) slot <= last ? '0 : slot + SEL_W'(1);
endmodule

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: steers a word-serial TDM stream into per-channel registers, one full frame at a time
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [W-1:0]      din,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] ch_data,
  output logic              frame_valid,
  output logic [SEL_W-1:0]  slot,
  output logic              locked,
  output logic              sync_err
);
  state_t state;
  logic [W-1:0] shadow [N_CH-1];
  logic [N_CH*W-1:0] frame;
  logic last, load1, data_beat, inc, clr;
  assign locked = (state == LOCK);
  assign load1 = din_valid & frame_sync;
  assign data_beat = din_valid & ~frame_sync & locked;
  assign inc = data_beat & (slot != '0);
  assign clr = data_beat & (slot == '0);
  tdm_slot_counter #(.N_CH(N_CH)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .load1(load1), .inc(inc), .slot(slot), .last(last)
  );
  // completed frame: buffered slots plus the final sample arriving this beat
  always_comb begin
    frame = '0;
    for (int k = 0; k < N_CH - 1; k++) frame[k*W +: W] = shadow[k];
    frame[(N_CH-1)*W +: W] = din;
  end
  // framing FSM, shadow capture, frame publication and one-cycle pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HUNT;
      ch_data <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
      for (int k = 0; k < N_CH - 1; k++) shadow[k] <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
      if (load1) begin
        shadow[0] <= din;
        state <= LOCK;
        sync_err <= locked && (slot != '0);
      end else if (clr) begin
        sync_err <= 1'b1;
        state <= HUNT;
      end else if (inc) begin
        if (last) begin
          ch_data <= frame;
          frame_valid <= 1'b1;
        end
        for (int k = 1; k < N_CH - 1; k++) if (slot == SEL_W'(k)) shadow[k] <= din;
      end
    end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: directed plus randomized checks of the TDM demux against a queue-based frame model
module tb_tdm_demux_4ch;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic frame_sync = 1'b0;
  logic [N*W-1:0] ch_data;
  logic frame_valid, locked, sync_err;
  logic [1:0] slot;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_locked = 0;
  bit m_fv = 0;
  bit m_err = 0;
  logic [N*W-1:0] m_ch = '0;
  logic [W-1:0] part[$];
  int fv_cnt = 0;
  int err_cnt = 0;

  tdm_demux_4ch #(.N_CH(N), .W(W)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .frame_sync(frame_sync),
    .ch_data(ch_data), .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ch_data"}, 64'(ch_data), 64'(m_ch));
    chk({tag, ".frame_valid"}, 64'(frame_valid), 64'(m_fv));
    chk({tag, ".sync_err"}, 64'(sync_err), 64'(m_err));
    chk({tag, ".locked"}, 64'(locked), 64'(m_locked));
    chk({tag, ".slot"}, 64'(slot), 64'(part.size()));
    chk({tag, ".exclusive"}, 64'(frame_valid & sync_err), 64'(0));
  endtask

  // frame-level reference: part holds the samples of the frame being collected
  task automatic model(input bit v, input bit fs, input logic [W-1:0] d);
    m_fv = 0;
    m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        part = {d};
        m_locked = 1;
      end
    end else if (fs) begin
      m_err = (part.size() != 0);
      part = {d};
    end else if (part.size() == 0) begin
      m_err = 1;
      m_locked = 0;
    end else begin
      part.push_back(d);
      if (part.size() == N) begin
        for (int k = 0; k < N; k++) m_ch[k*W +: W] = part[k];
        m_fv = 1;
        part = {};
      end
    end
  endtask

  task automatic step(input string tag, input bit v, input bit fs, input logic [W-1:0] d);
    @(negedge clk);
    din_valid = v;
    frame_sync = fs;
    din = d;
    @(posedge clk);
    #1;
    model(v, fs, d);
    if (frame_valid) fv_cnt++;
    if (sync_err) err_cnt++;
    check_all(tag);
  endtask

  task automatic frame(input string tag, input logic [W-1:0] a, b, c, e, input int gap);
    logic [W-1:0] s[4];
    s = '{a, b, c, e};
    for (int i = 0; i < 4; i++) begin
      step(tag, 1, i == 0, s[i]);
      for (int g = 0; g < gap; g++) step({tag, ".gap"}, 0, 0, 8'($urandom));
    end
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    step("idle", 0, 0, 8'h00);
    // 1: basic frame
    frame("t1", 8'h11, 8'h22, 8'h33, 8'h44, 0);
    chk("t1.value", 64'(ch_data), 64'h44332211);
    chk("t1.fv", 64'(frame_valid), 64'd1);
    step("t1.after", 0, 0, 8'h00);
    chk("t1.fv_low", 64'(frame_valid), 64'd0);
    // 2: gaps of 1..3 cycles between beats
    for (int r = 0; r < 3; r++) frame("t2", 8'h11, 8'h22, 8'h33, 8'h44, 1 + r);
    chk("t2.value", 64'(ch_data), 64'h44332211);
    // 3: early sync drops the partial frame
    frame("t3.good", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    step("t3.a1", 1, 1, 8'hA1);
    step("t3.a2", 1, 0, 8'hA2);
    step("t3.b1", 1, 1, 8'hB1);
    chk("t3.err", 64'(sync_err), 64'd1);
    step("t3.b2", 1, 0, 8'hB2);
    step("t3.b3", 1, 0, 8'hB3);
    step("t3.b4", 1, 0, 8'hB4);
    chk("t3.value", 64'(ch_data), 64'hB4B3B2B1);
    // 4: missing sync drops lock
    frame("t4.good", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    for (int i = 0; i < 4; i++) step("t4.nosync", 1, 0, 8'($urandom));
    chk("t4.unlocked", 64'(locked), 64'd0);
    frame("t4.relock", 8'h5A, 8'h6B, 8'h7C, 8'h8D, 0);
    chk("t4.value", 64'(ch_data), 64'h8D7C6B5A);
    // 5: async reset mid-frame
    step("t5.s0", 1, 1, 8'hC1);
    step("t5.s1", 1, 0, 8'hC2);
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_locked = 0; m_fv = 0; m_err = 0; m_ch = '0; part = {};
    check_all("t5.async");
    @(posedge clk);
    #1 check_all("t5.held");
    @(negedge clk);
    rst = 1'b0;
    frame("t5.new", 8'h01, 8'h02, 8'h03, 8'h04, 0);
    chk("t5.value", 64'(ch_data), 64'h04030201);
    // 6: three back-to-back frames, continuous valid
    fv_cnt = 0;
    err_cnt = 0;
    for (int f = 0; f < 3; f++) frame("t6", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    chk("t6.fv_count", 64'(fv_cnt), 64'd3);
    chk("t6.err_count", 64'(err_cnt), 64'd0);
    // randomized soak, mostly well-formed framing with occasional violations
    for (int i = 0; i < 400; i++) begin
      bit v, fs;
      v = $urandom_range(0, 3) != 0;
      fs = (part.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      step("soak", v, fs, 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
